// File: rtl/uart_rx_fifo.sv
// UART receiver (7/8 data bits, optional odd/even parity) feeding a 4-entry
// FIFO of {ferr, perr, data} entries with a sticky overflow flag.
module uart_rx_fifo (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        eight,
    input  logic        pen,
    input  logic        ohel,
    input  logic [18:0] k,
    input  logic        rd,
    output logic [7:0]  data,
    output logic        rxrdy,
    output logic        ferr,
    output logic        perr,
    output logic        ovf,
    output logic        full
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      r_state;
    logic        r_s1, r_s2, r_s3;
    logic [18:0] r_timer;
    logic [18:0] r_k;
    logic        r_eight, r_pen, r_ohel;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_perr;
    logic        r_push;
    logic [9:0]  r_push_ent;

    logic [9:0]  r_mem [4];
    logic [1:0]  r_wp, r_rp;
    logic [2:0]  r_cnt;
    logic        r_ovf;

    logic        w_rx;
    logic        w_fall;
    logic [18:0] w_lim;
    logic        w_tick;
    logic        w_last;
    logic        w_rd_acc;
    logic        w_wr;
    logic        w_ovf_set;
    logic [9:0]  w_head;

    // r_s3 is only an edge-detect history bit; decoding uses r_s2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= rx;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rx   = r_s2;
    assign w_fall = r_s3 & ~r_s2;
    assign w_lim  = (r_state == START) ? ({1'b0, r_k[18:1]} - 19'd1) : (r_k - 19'd1);
    assign w_tick = (r_timer == w_lim);
    assign w_last = r_eight ? (r_bitcnt == 3'd7) : (r_bitcnt == 3'd6);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_k        <= '0;
            r_eight    <= 1'b0;
            r_pen      <= 1'b0;
            r_ohel     <= 1'b0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_push     <= 1'b0;
            r_push_ent <= '0;
        end else begin
            r_push <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state  <= START;
                        r_timer  <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                        r_perr   <= 1'b0;
                        r_k      <= k;
                        r_eight  <= eight;
                        r_pen    <= pen;
                        r_ohel   <= ohel;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_state <= w_rx ? IDLE : DATA;
                    end else begin
                        r_timer <= r_timer + 19'd1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_timer           <= '0;
                        r_shift[r_bitcnt] <= w_rx;
                        r_bitcnt          <= r_bitcnt + 3'd1;
                        if (w_last)
                            r_state <= r_pen ? PARITY : STOP;
                    end else begin
                        r_timer <= r_timer + 19'd1;
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_perr  <= (((^r_shift) ^ w_rx) != r_ohel);
                        r_state <= STOP;
                    end else begin
                        r_timer <= r_timer + 19'd1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_timer    <= '0;
                        r_bitcnt   <= '0;
                        r_push     <= 1'b1;
                        r_push_ent <= {~w_rx, r_perr, r_shift};
                        r_state    <= IDLE;
                    end else begin
                        r_timer <= r_timer + 19'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A pending push lands one edge after the stop sample; rd frees the slot
    // in the same edge, so a full FIFO with rd still accepts the frame.
    assign w_rd_acc  = rd && (r_cnt != 3'd0);
    assign w_wr      = r_push && ((r_cnt != 3'd4) || rd);
    assign w_ovf_set = r_push && (r_cnt == 3'd4) && !rd;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= r_push_ent;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + 2'd1;
            if (w_rd_acc)
                r_rp <= r_rp + 2'd1;
            unique case ({w_wr, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_rd_acc)
                r_ovf <= 1'b0;
        end
    end

    assign w_head = (r_cnt != 3'd0) ? r_mem[r_rp] : 10'd0;
    assign data   = w_head[7:0];
    assign perr   = w_head[8];
    assign ferr   = w_head[9];
    assign rxrdy  = (r_cnt != 3'd0);
    assign full   = (r_cnt == 3'd4);
    assign ovf    = r_ovf;

endmodule
